// File: rtl/eth_frame_buf.sv
// eth_frame_buf: byte frame buffer with commit/discard, committed-length queue and a frame read FSM.
// Define ETH_FRAME_BUF_OREG_EN to add an output register stage on the read port.
module eth_frame_buf #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int LQ_W   = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_eof,
    input  logic              i_wr_err,
    output logic              o_wr_full,
    output logic [15:0]       o_drop_cnt,
    output logic              o_frm_valid,
    output logic [ADDR_W:0]   o_frm_len,
    input  logic              i_rd_start,
    output logic              o_busy,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_last
);
    localparam int PW = ADDR_W + 1;
    localparam int QW = LQ_W + 1;
    localparam logic [PW-1:0] P1 = PW'(1);
    localparam logic [QW-1:0] Q1 = QW'(1);
    localparam logic [PW-1:0] DEPTH = P1 << ADDR_W;
    localparam logic [QW-1:0] QDEPTH = Q1 << LQ_W;

    typedef enum logic {IDLE = 1'b0, RD = 1'b1} state_t;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [PW-1:0]     lq_mem [2**LQ_W];

    state_t            state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, wr_cmt_q, wr_cmt_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     len_q, len_d, remain_q, remain_d;
    logic [QW-1:0]     lq_wr_q, lq_wr_d, lq_rd_q, lq_rd_d;
    logic              bad_q, bad_d, full_q, full_d;
    logic [15:0]       drop_q, drop_d;
    logic              rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic no_space, lq_full, frm_valid, pop, wr_ok, eof, commit, discard;

    always_comb begin
        no_space  = (wr_ptr_q - rd_ptr_q) == DEPTH;
        lq_full   = (lq_wr_q - lq_rd_q) == QDEPTH;
        frm_valid = lq_wr_q != lq_rd_q;
        pop       = state_q == IDLE && i_rd_start && frm_valid;
        wr_ok     = i_wr_en && !no_space && !bad_q;
        eof       = i_wr_en && i_wr_eof;
        // An eof word that finds no space poisons its own frame
        commit    = eof && !i_wr_err && !bad_q && !no_space && (!lq_full || pop);
        discard   = eof && !commit;
    end

    always_comb begin
        wr_ptr_d = discard ? wr_cmt_q : (wr_ok ? wr_ptr_q + P1 : wr_ptr_q);
        wr_cmt_d = commit ? wr_ptr_q + P1 : wr_cmt_q;
        len_d    = eof ? '0 : (wr_ok ? len_q + P1 : len_q);
        bad_d    = eof ? 1'b0 : (bad_q || (i_wr_en && no_space));
        drop_d   = (discard && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
        lq_wr_d  = commit ? lq_wr_q + Q1 : lq_wr_q;
        lq_rd_d  = pop ? lq_rd_q + Q1 : lq_rd_q;
        rd_ptr_d = state_q == RD ? rd_ptr_q + P1 : rd_ptr_q;
        remain_d = pop ? lq_mem[lq_rd_q[LQ_W-1:0]] : (state_q == RD ? remain_q - P1 : remain_q);
        rdata_d  = state_q == RD ? mem[rd_ptr_q[ADDR_W-1:0]] : rdata_q;
        full_d   = (wr_ptr_d - rd_ptr_d) == DEPTH || (lq_wr_d - lq_rd_d) == QDEPTH;
    end

    always_comb begin
        state_d = state_q == IDLE ? (pop ? RD : IDLE) : (remain_q == P1 ? IDLE : RD);
    end

    always_comb begin
        rvalid_d = state_q == RD;
        rlast_d  = state_q == RD && remain_q == P1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            wr_cmt_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
            remain_q <= '0;
            lq_wr_q  <= '0;
            lq_rd_q  <= '0;
            bad_q    <= 1'b0;
            full_q   <= 1'b0;
            drop_q   <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            wr_cmt_q <= wr_cmt_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
            remain_q <= remain_d;
            lq_wr_q  <= lq_wr_d;
            lq_rd_q  <= lq_rd_d;
            bad_q    <= bad_d;
            full_q   <= full_d;
            drop_q   <= drop_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
            rdata_q  <= rdata_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_ok) mem[wr_ptr_q[ADDR_W-1:0]] <= i_wr_data;
        if (commit) lq_mem[lq_wr_q[LQ_W-1:0]] <= len_q + P1;
    end

    assign o_wr_full   = full_q;
    assign o_drop_cnt  = drop_q;
    assign o_frm_valid = frm_valid;
    assign o_frm_len   = frm_valid ? lq_mem[lq_rd_q[LQ_W-1:0]] : '0;
    assign o_busy      = state_q == RD;

`ifdef ETH_FRAME_BUF_OREG_EN
    logic [DATA_W-1:0] odata_q;
    logic              ovalid_q, olast_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            olast_q  <= 1'b0;
        end else begin
            odata_q  <= rdata_q;
            ovalid_q <= rvalid_q;
            olast_q  <= rlast_q;
        end
    end

    assign o_rd_data  = odata_q;
    assign o_rd_valid = ovalid_q;
    assign o_rd_last  = olast_q;
`else
    assign o_rd_data  = rdata_q;
    assign o_rd_valid = rvalid_q;
    assign o_rd_last  = rlast_q;
`endif
endmodule
